// File: rtl/present_pkg.sv
// Shared PRESENT-style 16-bit cipher primitives and the engine state type.
package present_pkg;

    localparam int ROUNDS_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY,
        ST_ROUND,
        ST_HOLD
    } state_e;

    // Nibble n of each table sits at bits [4n+3:4n].
    localparam logic [63:0] SBOX_TBL     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX_TBL = 64'hA970_364B_D21C_8FE5;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        return SBOX_TBL[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        return INV_SBOX_TBL[{n, 2'b00} +: 4];
    endfunction

    // Destination of bit i under the forward bit permutation.
    function automatic logic [3:0] p_idx(input logic [3:0] i);
        logic [5:0] m;
        m = {i, 2'b00} % 6'd15;
        return (i == 4'd15) ? 4'd15 : m[3:0];
    endfunction

    function automatic logic [19:0] next_key(input logic [19:0] k, input logic [4:0] r);
        logic [19:0] t;
        t         = {k[12:0], k[19:13]};
        t[19:16]  = sbox(t[19:16]);
        t[7:3]    = t[7:3] ^ r;
        return t;
    endfunction

endpackage

// File: rtl/present_inv_round.sv
// One combinational inverse round: undo bit permutation, undo S-box, strip round key.
module present_inv_round
    import present_pkg::*;
(
    input  logic [15:0] state_i,
    input  logic [15:0] rkey_i,
    output logic [15:0] state_o
);

    logic [15:0] unperm;
    logic [15:0] unsub;

    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_perm
        assign unperm[gi] = state_i[p_idx(4'(gi))];
    end

    for (gi = 0; gi < 4; gi++) begin : g_sbox
        assign unsub[4*gi +: 4] = inv_sbox(unperm[4*gi +: 4]);
    end

    assign state_o = unsub ^ rkey_i;

endmodule

// File: rtl/cbc_decrypt_engine.sv
// CBC-mode block decryptor: expands the key once per configuration, then
// runs one inverse round per cycle per 16-bit ciphertext block.
module cbc_decrypt_engine
    import present_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int NBLK   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [19:0] key,
    input  logic [15:0] init_vec,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ct_block,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pt_block,
    output logic        out_last
);

    localparam int RW = $clog2(ROUNDS + 1);
    localparam int CW = (NBLK > 1) ? $clog2(NBLK) : 1;

    state_e          state_q;
    logic [19:0]     kreg_q;
    logic [15:0]     iv_q;
    logic [15:0]     chain_q;
    logic [15:0]     data_q;
    logic [15:0]     ct_save_q;
    logic [15:0]     pt_q;
    logic [RW-1:0]   cnt_q;
    logic [CW-1:0]   blk_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [15:0]     key_q [ROUNDS+1];

    logic [RW-1:0]   rk_idx;
    logic [15:0]     round_out;
    logic            cfg_hs;
    logic            in_hs;

    // A simultaneous key offer in READY wins; the block is simply not accepted.
    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_READY);
    assign in_ready  = ((state_q == ST_READY) && !cfg_valid) ||
                       ((state_q == ST_HOLD) && out_ready);
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign in_hs     = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign pt_block  = pt_q;

    assign rk_idx = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

    present_inv_round u_round (
        .state_i (data_q),
        .rkey_i  (key_q[rk_idx]),
        .state_o (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ROUNDS; i++) key_q[i] <= '0;
        end else if (state_q == ST_EXPAND) begin
            key_q[cnt_q] <= kreg_q[19:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kreg_q      <= '0;
            iv_q        <= '0;
            chain_q     <= '0;
            data_q      <= '0;
            ct_save_q   <= '0;
            pt_q        <= '0;
            cnt_q       <= '0;
            blk_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (cfg_hs) begin
                        kreg_q  <= key;
                        iv_q    <= init_vec;
                        chain_q <= init_vec;
                        blk_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_EXPAND;
                    end else if (in_hs) begin
                        data_q    <= ct_block ^ key_q[ROUNDS];
                        ct_save_q <= ct_block;
                        cnt_q     <= RW'(ROUNDS);
                        state_q   <= ST_ROUND;
                    end
                end
                ST_EXPAND: begin
                    kreg_q <= next_key(kreg_q, 5'(cnt_q + 1'b1));
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == RW'(ROUNDS)) state_q <= ST_READY;
                end
                ST_ROUND: begin
                    if (cnt_q == '0) begin
                        pt_q        <= data_q ^ chain_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (blk_q == CW'(NBLK - 1));
                        chain_q     <= ct_save_q;
                        state_q     <= ST_HOLD;
                    end else begin
                        data_q <= round_out;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        blk_q       <= out_last_q ? '0 : blk_q + 1'b1;
                        if (out_last_q) chain_q <= iv_q;
                        if (in_hs) begin
                            data_q    <= ct_block ^ key_q[ROUNDS];
                            ct_save_q <= ct_block;
                            cnt_q     <= RW'(ROUNDS);
                            state_q   <= ST_ROUND;
                        end else begin
                            state_q <= ST_READY;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbc_decrypt_engine.sv
// Randomised bench: messages are CBC-encrypted by a forward-cipher model and
// the decrypted stream is compared block by block.
module tb_cbc_decrypt_engine;

    localparam int R  = 8;
    localparam int NB = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [19:0] key       = '0;
    logic [15:0] init_vec  = '0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] ct_block  = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] pt_block;
    logic        out_last;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cbc_decrypt_engine #(.ROUNDS(R), .NBLK(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .key       (key),
        .init_vec  (init_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct_block  (ct_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt_block  (pt_block),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] sb(input logic [3:0] n);
        case (n)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [15:0] encrypt(input logic [15:0] p, input logic [19:0] k);
        logic [15:0] rk [R+2];
        logic [19:0] kk;
        logic [15:0] s, t;
        kk = k;
        for (int r = 1; r <= R + 1; r++) begin
            rk[r]     = kk[19:4];
            kk        = {kk[12:0], kk[19:13]};
            kk[19:16] = sb(kk[19:16]);
            kk[7:3]   = kk[7:3] ^ 5'(r);
        end
        s = p;
        for (int r = 1; r <= R; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 4; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
            t = '0;
            for (int i = 0; i < 15; i++) t[(4*i) % 15] = s[i];
            t[15] = s[15];
            s = t;
        end
        return s ^ rk[R+1];
    endfunction

    task automatic configure(input logic [19:0] k, input logic [15:0] iv, input string tag);
        int t0, lat;
        @(negedge clk);
        in_valid  = 1'b0;
        cfg_valid = 1'b1;
        key       = k;
        init_vec  = iv;
        #1;
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        t0 = cyc + 1;
        @(negedge clk);
        cfg_valid = 1'b0;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (in_ready) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_cfg_to_in_ready"}, 32'(lat), 32'd9);
        $display("%s configured key=%h iv=%h", tag, k, iv);
    endtask

    // mode 0: always ready; 1: random gaps and backpressure; 2: 5-cycle stall on block 3
    task automatic run_message(input logic [127:0] msg, input logic [19:0] k,
                               input logic [15:0] iv, input int mode, input string tag);
        logic [15:0] pt [NB];
        logic [15:0] ct [NB];
        logic [15:0] prev, hold_pt;
        logic        held, hold_last;
        int sent, rcv, stalled, acc0, first_ov;
        prev = iv;
        for (int i = 0; i < NB; i++) begin
            pt[i] = msg[127 - 16*i -: 16];
            ct[i] = encrypt(pt[i] ^ prev, k);
            prev  = ct[i];
        end
        sent = 0; rcv = 0; stalled = 0; acc0 = -1; first_ov = -1;
        held = 1'b0; hold_pt = '0; hold_last = 1'b0;
        for (int c = 0; c < 3000 && rcv < NB; c++) begin
            @(negedge clk);
            if (held) begin
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_pt"}, 32'(pt_block), 32'(hold_pt));
                check({tag, "_hold_last"}, 32'(out_last), 32'(hold_last));
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (mode == 2 && out_valid && rcv == 2 && stalled < 5) begin
                out_ready = 1'b0;
                stalled++;
            end else if (mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (sent < NB) && (mode != 1 || $urandom_range(0, 2) != 0);
            ct_block = (sent < NB) ? ct[sent] : 16'h0;
            #1;
            if (out_valid && !out_ready) begin
                check({tag, "_in_ready_stalled"}, 32'(in_ready), 32'd0);
                held = 1'b1; hold_pt = pt_block; hold_last = out_last;
            end else begin
                held = 1'b0;
            end
            if (in_valid && in_ready) begin
                if (sent == 0) acc0 = cyc + 1;
                sent++;
            end
            if (out_valid && out_ready) begin
                check({tag, "_pt"}, 32'(pt_block), 32'(pt[rcv]));
                check({tag, "_last"}, 32'(out_last), 32'(rcv == NB - 1));
                $display("%s blk%0d pt=%h last=%0b", tag, rcv, pt_block, out_last);
                rcv++;
            end
        end
        check({tag, "_blocks_received"}, 32'(rcv), 32'(NB));
        check({tag, "_accept_to_out_valid"}, 32'(first_ov - acc0), 32'd9);
        if (mode == 2) check({tag, "_stall_cycles"}, 32'(stalled), 32'd5);
    endtask

    initial begin : main
        logic [127:0] m;
        logic [19:0]  k;
        logic [15:0]  iv, prev;
        logic [15:0]  ct [NB];
        int           sent;
        logic         ov_seen;

        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pt_block", 32'(pt_block), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("post_rst_out_last", 32'(out_last), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd0);

        configure(20'h48FA2, 16'hA63E, "msg_a");
        run_message({8{16'h4444}}, 20'h48FA2, 16'hA63E, 0, "msg_a");
        // Same key, no reconfiguration: exercises IV reload after the last block.
        run_message({{16'h4444, 16'h4544}, {6{16'h4444}}}, 20'h48FA2, 16'hA63E, 0, "msg_b");
        configure(20'hB00B5, 16'hAB84, "msg_c");
        run_message(128'hBADDCAFEBADDF00DD15EA5EDDEADBEEF, 20'hB00B5, 16'hAB84, 0, "msg_c");
        run_message(128'h0123456789ABCDEFFEDCBA9876543210, 20'hB00B5, 16'hAB84, 2, "stall");

        for (int n = 0; n < 5; n++) begin
            k  = 20'($urandom);
            iv = 16'($urandom);
            m  = {$urandom, $urandom, $urandom, $urandom};
            configure(k, iv, $sformatf("rnd%0d", n));
            run_message(m, k, iv, 1, $sformatf("rnd%0d", n));
        end

        // Reset while block 4 is mid-round.
        k  = 20'h48FA2;
        iv = 16'hA63E;
        m  = {$urandom, $urandom, $urandom, $urandom};
        prev = iv;
        for (int i = 0; i < NB; i++) begin
            ct[i] = encrypt(m[127 - 16*i -: 16] ^ prev, k);
            prev  = ct[i];
        end
        configure(k, iv, "rstmid");
        sent = 0;
        for (int c = 0; c < 300 && sent < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            ct_block  = ct[sent];
            #1;
            if (in_ready) sent++;
        end
        check("rstmid_blocks_sent", 32'(sent), 32'd4);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_pt_block", 32'(pt_block), 32'd0);
        check("rstmid_out_last", 32'(out_last), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ov_seen |= out_valid;
        end
        check("rstmid_no_partial_output", 32'(ov_seen), 32'd0);
        configure(k, iv, "rstmid_re");
        run_message(m, k, iv, 1, "rstmid_re");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
